switch_arbiter: RTL and testbench

//  Output-port allocator for the 5-port (L,N,E,S,W) NoC switch crossbar. Decodes each input's
//  3-bit request (destination port), runs one round-robin arbiter per output with wormhole lock
//  and a starvation guard, and drives per-input grants plus per-output crossbar selects.

---
 rtl/noc_pkg.sv | 39 +++
 rtl/switch_arbiter_if.sv | 22 ++
 rtl/switch_arbiter_rr_port_arbiter.sv | 73 +++++++
 rtl/switch_arbiter.sv | 65 ++++++
 tb/tb_switch_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared port indices, idle select code, arbiter state type and request helpers
package noc_pkg;
    localparam int NPORT = 5;
    localparam logic [2:0] PORT_L = 3'd0;
    localparam logic [2:0] PORT_N = 3'd1;
    localparam logic [2:0] PORT_E = 3'd2;
    localparam logic [2:0] PORT_S = 3'd3;
    localparam logic [2:0] PORT_W = 3'd4;
    localparam logic [2:0] IDLE_CODE = 3'd7;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    // Codes 5..7 mean "no request".
    function automatic logic dest_valid(input logic [2:0] code);
        return code < 3'(NPORT);
    endfunction

    function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
        return idx == 3'(NPORT - 1) ? 3'd0 : idx + 3'd1;
    endfunction

    // First set bit of r searching start+1, start+2, ... wrapping, start itself last.
    function automatic logic [2:0] rr_pick(input logic [NPORT-1:0] r, input logic [2:0] start);
        logic [2:0] idx;
        logic [2:0] res;
        logic found;
        idx = start;
        res = start;
        found = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            idx = wrap_inc(idx);
            if (!found && r[idx]) begin
                res = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/switch_arbiter_if.sv
// switch_arbiter_if: request/grant/select bundle between the switch datapath and its allocator
//   request_* : 3-bit destination per input (5..7 = none)
//   grant_*   : input owns the output it requests
//   sel_*     : input index driving each output, IDLE_CODE when undriven
//   master modport drives requests, slave modport (the arbiter) drives grants and selects
interface switch_arbiter_if;
    logic [2:0] request_L, request_N, request_E, request_S, request_W;
    logic       grant_L, grant_N, grant_E, grant_S, grant_W;
    logic [2:0] sel_L, sel_N, sel_E, sel_S, sel_W;

    modport master (
        output request_L, request_N, request_E, request_S, request_W,
        input  grant_L, grant_N, grant_E, grant_S, grant_W,
        input  sel_L, sel_N, sel_E, sel_S, sel_W
    );

    modport slave (
        input  request_L, request_N, request_E, request_S, request_W,
        output grant_L, grant_N, grant_E, grant_S, grant_W,
        output sel_L, sel_N, sel_E, sel_S, sel_W
    );
endinterface

// File: rtl/switch_arbiter_rr_port_arbiter.sv
// rr_port_arbiter: round-robin allocator for one output with wormhole lock and starvation guard
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   req   : one bit per input requesting this output
//   owner : input currently holding the output (valid while busy)
//   busy  : output is allocated
module rr_port_arbiter
    import noc_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    localparam int CW = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req,
    output logic [2:0]       owner,
    output logic             busy
);
    localparam logic [CW-1:0] CMAX = CW'(HOLD_MAX - 1);

    arb_state_t       state, state_d;
    logic [2:0]       owner_q, owner_d, ptr, ptr_d;
    logic [CW-1:0]    count, count_d;
    logic [NPORT-1:0] own_mask, others;
    logic             keep;

    // Pointer resets to the last input so input L wins the first arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            owner_q <= PORT_L;
            ptr     <= PORT_W;
            count   <= '0;
        end else begin
            state   <= state_d;
            owner_q <= owner_d;
            ptr     <= ptr_d;
            count   <= count_d;
        end
    end

    assign own_mask = NPORT'(1) << owner_q;
    assign others   = req & ~own_mask;
    assign keep     = state == ARB_BUSY && req[owner_q];

    // A dropped owner is replaced on the same edge, so no idle bubble appears.
    always_comb begin
        state_d = state;
        owner_d = owner_q;
        ptr_d   = ptr;
        count_d = count;
        if (keep && |others && count == CMAX) begin
            owner_d = rr_pick(others, owner_q);
            ptr_d   = owner_d;
            count_d = '0;
        end else if (keep) begin
            count_d = count == CMAX ? count : count + CW'(1);
        end else if (|req) begin
            state_d = ARB_BUSY;
            owner_d = rr_pick(req, ptr);
            ptr_d   = owner_d;
            count_d = '0;
        end else begin
            state_d = ARB_IDLE;
            count_d = '0;
        end
    end

    always_comb begin
        busy  = state == ARB_BUSY;
        owner = owner_q;
    end
endmodule

// File: rtl/switch_arbiter.sv
// switch_arbiter: output-port allocator for the 5-port NoC crossbar
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of switch_arbiter_if (requests in, grants and crossbar selects out)
module switch_arbiter
    import noc_pkg::*;
#(
    parameter int         HOLD_MAX  = 16,
    parameter logic [2:0] IDLE_CODE = noc_pkg::IDLE_CODE
) (
    input  logic              clk,
    input  logic              rst,
    switch_arbiter_if.slave   bus
);
    logic [2:0]       request [NPORT];
    logic [NPORT-1:0] req     [NPORT];
    logic [2:0]       owner   [NPORT];
    logic [2:0]       sel     [NPORT];
    logic [NPORT-1:0] busy, grant;

    assign request[PORT_L] = bus.request_L;
    assign request[PORT_N] = bus.request_N;
    assign request[PORT_E] = bus.request_E;
    assign request[PORT_S] = bus.request_S;
    assign request[PORT_W] = bus.request_W;

    // req[o][i]: input i wants output o.
    always_comb begin
        req = '{default: '0};
        for (int o = 0; o < NPORT; o++)
            for (int i = 0; i < NPORT; i++)
                req[o][i] = dest_valid(request[i]) && request[i] == 3'(o);
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_arb
        rr_port_arbiter #(.HOLD_MAX(HOLD_MAX)) u_arb (
            .clk   (clk),
            .rst   (rst),
            .req   (req[o]),
            .owner (owner[o]),
            .busy  (busy[o])
        );
    end

    // Each input requests a single output, so at most one term per input is set.
    always_comb begin
        grant = '0;
        for (int o = 0; o < NPORT; o++) begin
            sel[o] = busy[o] ? owner[o] : IDLE_CODE;
            for (int i = 0; i < NPORT; i++)
                grant[i] = grant[i] | (busy[o] && owner[o] == 3'(i));
        end
    end

    assign bus.grant_L = grant[PORT_L];
    assign bus.grant_N = grant[PORT_N];
    assign bus.grant_E = grant[PORT_E];
    assign bus.grant_S = grant[PORT_S];
    assign bus.grant_W = grant[PORT_W];
    assign bus.sel_L   = sel[PORT_L];
    assign bus.sel_N   = sel[PORT_N];
    assign bus.sel_E   = sel[PORT_E];
    assign bus.sel_S   = sel[PORT_S];
    assign bus.sel_W   = sel[PORT_W];
endmodule

// File: tb/tb_switch_arbiter.sv
// tb_switch_arbiter: scoreboard bench for switch_arbiter with HOLD_MAX=4
module tb_switch_arbiter;
    localparam int HOLD = 4;

    typedef struct packed {
        logic [4:0]  g;
        logic [14:0] s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_pass = 0;
    exp_t sb[$];

    int m_busy [5];
    int m_owner[5];
    int m_ptr  [5];
    int m_cnt  [5];

    switch_arbiter_if bus();

    switch_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [4:0] dut_grants();
        return {bus.grant_W, bus.grant_S, bus.grant_E, bus.grant_N, bus.grant_L};
    endfunction

    function automatic logic [14:0] dut_sels();
        return {bus.sel_W, bus.sel_S, bus.sel_E, bus.sel_N, bus.sel_L};
    endfunction

    function automatic int first_after(input int start, input bit [4:0] r);
        for (int k = 1; k <= 5; k++)
            if (r[(start + k) % 5]) return (start + k) % 5;
        return -1;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < 5; o++) begin
            m_busy[o] = 0;
            m_owner[o] = 0;
            m_ptr[o] = 4;
            m_cnt[o] = 0;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.g = '0;
        e.s = {5{3'd7}};
        for (int o = 0; o < 5; o++)
            if (m_busy[o] != 0) begin
                e.g[m_owner[o]] = 1'b1;
                e.s[o*3 +: 3] = 3'(m_owner[o]);
            end
        return e;
    endfunction

    task automatic model_step(input int rq[5]);
        bit [4:0] r;
        bit [4:0] oth;
        for (int o = 0; o < 5; o++) begin
            r = '0;
            for (int i = 0; i < 5; i++) r[i] = (rq[i] == o);
            if (m_busy[o] != 0 && r[m_owner[o]]) begin
                oth = r;
                oth[m_owner[o]] = 1'b0;
                if (oth == 0) m_cnt[o] = (m_cnt[o] + 1 > HOLD - 1) ? HOLD - 1 : m_cnt[o] + 1;
                else if (m_cnt[o] < HOLD - 1) m_cnt[o]++;
                else begin
                    m_owner[o] = first_after(m_owner[o], oth);
                    m_ptr[o] = m_owner[o];
                    m_cnt[o] = 0;
                end
            end else if (r != 0) begin
                m_busy[o] = 1;
                m_owner[o] = first_after(m_ptr[o], r);
                m_ptr[o] = m_owner[o];
                m_cnt[o] = 0;
            end else begin
                m_busy[o] = 0;
                m_cnt[o] = 0;
            end
        end
    endtask

    task automatic cycle(input int l, input int n, input int e, input int s, input int w);
        int   rq[5];
        exp_t x;
        @(negedge clk);
        rq = '{l, n, e, s, w};
        bus.request_L = 3'(l);
        bus.request_N = 3'(n);
        bus.request_E = 3'(e);
        bus.request_S = 3'(s);
        bus.request_W = 3'(w);
        model_step(rq);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("grant", 32'(dut_grants()), 32'(x.g));
        check("sel", 32'(dut_sels()), 32'(x.s));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sel"}, 32'(dut_sels()), 32'h7fff);
        check({tag, "_grant"}, 32'(dut_grants()), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.request_L = 3'd7;
        bus.request_N = 3'd7;
        bus.request_E = 3'd7;
        bus.request_S = 3'd7;
        bus.request_W = 3'd7;
        model_reset();
        // reset state, and still idle after release
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) cycle(7, 7, 7, 7, 7);
        check_idle("post_reset");

        // single requester W to output L
        repeat (3) cycle(7, 7, 7, 7, 0);
        check("w_sel_L", 32'(bus.sel_L), 32'd4);
        check("w_grant", 32'(bus.grant_W), 32'd1);
        cycle(7, 7, 7, 7, 7);

        // all five contend for E: rotation every HOLD cycles
        do_reset();
        for (int c = 0; c < 22; c++) begin
            cycle(2, 2, 2, 2, 2);
            check("onehot", 32'($countones(dut_grants())), 32'd1);
            check("rot_sel_E", 32'(bus.sel_E), 32'((c / HOLD) % 5));
        end

        // W locks L, E joins L and S takes E, then handover; W later drops early
        do_reset();
        cycle(7, 7, 7, 7, 0);
        for (int c = 0; c < 6; c++) cycle(7, 7, 0, 2, 0);
        check("s_on_E", 32'(bus.sel_E), 32'd3);
        cycle(7, 7, 7, 7, 7);
        cycle(7, 7, 7, 7, 0);
        cycle(7, 7, 0, 7, 0);
        cycle(7, 7, 0, 7, 7);
        check("no_bubble", 32'(bus.sel_L), 32'd2);

        // unused request codes are ignored
        cycle(7, 5, 0, 7, 7);
        cycle(7, 6, 0, 7, 7);
        check("n_code_idle", 32'(bus.grant_N), 32'd0);

        // asynchronous reset mid-lock, then L beats W for N
        cycle(1, 7, 7, 7, 1);
        cycle(1, 7, 7, 7, 1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_idle("async_rst");
        @(negedge clk);
        rst = 1'b1;
        cycle(1, 7, 7, 7, 1);
        check("l_first_sel_N", 32'(bus.sel_N), 32'd0);
        check("l_first_grant", 32'(bus.grant_L), 32'd1);

        // random traffic, biased toward contention
        for (int c = 0; c < 80; c++)
            cycle($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
